// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store memory port.
package lsu_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_e;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_e;

    function automatic logic f3_legal(input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: f3_legal = 1'b1;
            default:                        f3_legal = 1'b0;
        endcase
    endfunction

    // Signedness is handled downstream, so B/BU and H/HU share a size.
    function automatic size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: f3_size = SZ_B;
            F3_H, F3_HU: f3_size = SZ_H;
            default:     f3_size = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_port_lane_align.sv
// Byte-lane steering: byte enables and store replication from size/offset,
// plus the load-data shift that brings the addressed lane down to bit 0.
module lsu_lane_align #(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       i_size,
    input  logic [1:0]       i_off,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [1:0]       i_rd_off,
    input  logic [WIDTH-1:0] i_rdata,
    output logic [3:0]       o_be,
    output logic [WIDTH-1:0] o_wdata,
    output logic [WIDTH-1:0] o_rdata
);
    import lsu_pkg::*;

    // Lane enables and replicated store data for the requested size.
    always_comb begin
        o_be    = 4'b0000;
        o_wdata = i_wdata;
        case (i_size)
            SZ_B: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {(WIDTH/8){i_wdata[7:0]}};
            end
            SZ_H: begin
                o_be    = 4'b0011 << i_off;
                o_wdata = {(WIDTH/16){i_wdata[15:0]}};
            end
            SZ_W: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
            end
            default: begin
                o_be    = 4'b0000;
                o_wdata = i_wdata;
            end
        endcase
    end

    assign o_rdata = i_rdata >> {i_rd_off, 3'b000};

endmodule

// File: rtl/lsu_mem_port.sv
// Sequential load/store port: one word-aligned request per access, stalls while busy.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses end in err instead of being force-aligned.
module lsu_mem_port #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_inst,
    input  logic [WIDTH-1:0] i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata_out,
    output logic             o_done,
    output logic             o_busy,
    output logic             o_err,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [3:0]       o_mem_be,
    output logic [WIDTH-1:0] o_mem_addr,
    output logic [WIDTH-1:0] o_mem_wdata,
    input  logic             i_mem_ready,
    input  logic [WIDTH-1:0] i_mem_rdata
);
    import lsu_pkg::*;

    localparam logic [7:0] TO_L = 8'(TIMEOUT);

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_inc;
    logic             r_we;
    logic [3:0]       r_be;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [1:0]       r_off;
    logic [WIDTH-1:0] r_rdata;

    logic [6:0]       w_opcode;
    logic [2:0]       w_f3;
    logic [1:0]       w_size;
    logic             w_is_mem;
    logic             w_accept;
    logic [1:0]       w_off;
    logic             w_misalign;
    logic             w_bad;
    logic [3:0]       w_be;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_rdata;
    logic             w_unused_inst;

    assign w_opcode      = i_inst[6:0];
    assign w_f3          = i_inst[14:12];
    assign w_size        = f3_size(w_f3);
    assign w_is_mem      = (w_opcode == OP_LOAD) || (w_opcode == OP_STORE);
    assign w_accept      = i_start && (r_state == IDLE) && w_is_mem;
    assign w_bad         = !f3_legal(w_f3) || w_misalign;
    assign w_cnt_inc     = r_cnt + 8'd1;
    assign w_unused_inst = ^{i_inst[WIDTH-1:15], i_inst[11:7]};

    // Effective lane offset and misalignment detection.
    always_comb begin
        w_off      = i_addr[1:0];
        w_misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        case (w_size)
            SZ_H:    w_misalign = i_addr[0];
            SZ_W:    w_misalign = (i_addr[1:0] != 2'b00);
            default: w_misalign = 1'b0;
        endcase
`else
        case (w_size)
            SZ_H:    w_off = {i_addr[1], 1'b0};
            SZ_W:    w_off = 2'b00;
            default: w_off = i_addr[1:0];
        endcase
`endif
    end

    lsu_lane_align #(.WIDTH(WIDTH)) u_lane (
        .i_size   (w_size),
        .i_off    (w_off),
        .i_wdata  (i_wdata),
        .i_rd_off (r_off),
        .i_rdata  (i_mem_rdata),
        .o_be     (w_be),
        .o_wdata  (w_wdata),
        .o_rdata  (w_rdata)
    );

    // Next-state and completion-error decode.
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_bad) begin
                        w_state_nxt = DONE;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = ACCESS;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACCESS: begin
                // A handshake on the timeout edge still completes cleanly.
                if (i_mem_ready) begin
                    w_state_nxt = DONE;
                end else if (w_cnt_inc == TO_L) begin
                    w_state_nxt = DONE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_state_nxt = ACCESS;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and error registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Wait counter: cleared outside ACCESS, counts cycles without ready.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 8'd0;
        end else if (r_state != ACCESS) begin
            r_cnt <= 8'd0;
        end else if (!i_mem_ready) begin
            r_cnt <= w_cnt_inc;
        end
    end

    // Request fields captured once per accepted start, held through the access.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we    <= 1'b0;
            r_be    <= 4'b0000;
            r_addr  <= '0;
            r_wdata <= '0;
            r_off   <= 2'b00;
        end else if (w_accept) begin
            r_we    <= (w_opcode == OP_STORE);
            r_be    <= w_be;
            r_addr  <= {i_addr[WIDTH-1:2], 2'b00};
            r_wdata <= w_wdata;
            r_off   <= w_off;
        end
    end

    // Load result updates only on a completed load handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if ((r_state == ACCESS) && i_mem_ready && !r_we) begin
            r_rdata <= w_rdata;
        end
    end

    assign o_rdata_out = r_rdata;
    assign o_done      = (r_state == DONE);
    assign o_busy      = (r_state != IDLE);
    assign o_err       = r_err;
    assign o_mem_req   = (r_state == ACCESS);
    assign o_mem_we    = r_we;
    assign o_mem_be    = r_be;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: request and completion expectations are
// queued at stimulus time and checked when the DUT presents them.
module tb_lsu_mem_port;

    localparam int TO = 4;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } req_t;

    typedef struct {
        logic        err;
        logic [31:0] rd;
    } cpl_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] inst = 32'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_data = 32'd0;
    int          mem_wait = 0;

    logic [31:0] o_rdata_out;
    logic        o_done, o_busy, o_err, o_mem_req, o_mem_we;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_addr, o_mem_wdata;

    req_t req_q[$];
    cpl_t cpl_q[$];
    int   n_total = 0;
    int   n_bad = 0;
    int   n_done = 0;
    int   n_reqs = 0;
    int   exp_dones = 0;
    int   exp_reqs = 0;
    int   k = 0;
    logic prev_req = 1'b0;
    logic [31:0] last_rd = 32'd0;

    lsu_mem_port #(.WIDTH(32), .TIMEOUT(TO)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_inst      (inst),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_rdata_out (o_rdata_out),
        .o_done      (o_done),
        .o_busy      (o_busy),
        .o_err       (o_err),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_be    (o_mem_be),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ready (mem_ready),
        .i_mem_rdata (mem_data)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory model: checks the request against the queue head every cycle it is up.
    always @(negedge clk) begin
        if (o_mem_req) begin
            if (req_q.size() == 0) begin
                chk_eq("req_unexpected", 32'(req_q.size()), 32'd1);
            end else begin
                chk_eq("req_addr", o_mem_addr, req_q[0].addr);
                chk_eq("req_be", 32'(o_mem_be), 32'(req_q[0].be));
                chk_eq("req_wdata", o_mem_wdata, req_q[0].wdata);
                chk_eq("req_we", 32'(o_mem_we), 32'(req_q[0].we));
            end
            mem_ready = (k >= mem_wait);
            k++;
        end else begin
            if (k > 0 && req_q.size() > 0) void'(req_q.pop_front());
            k = 0;
            mem_ready = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (o_done) n_done++;
        if (o_mem_req && !prev_req) n_reqs++;
        prev_req = o_mem_req;
        if (!o_done) chk_eq("err_outside_done", 32'(o_err), 32'd0);
    end

    task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] mdata, input int wait_c,
                         input bit hold, input bit exp_req, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input bit exp_err, input logic [31:0] exp_rd);
        req_t r;
        cpl_t c;
        int   n;
        int   exp_lat;
        bit   seen;
        mem_data = mdata;
        mem_wait = wait_c;
        if (exp_req) begin
            r.addr  = {a[31:2], 2'b00};
            r.be    = exp_be;
            r.wdata = exp_wd;
            r.we    = (op == OP_ST);
            req_q.push_back(r);
            exp_reqs++;
        end
        c.err = exp_err;
        c.rd  = exp_rd;
        cpl_q.push_back(c);
        exp_dones++;
        exp_lat = !exp_req ? 1 : ((wait_c >= TO) ? TO + 1 : wait_c + 2);
        inst  = {17'd0, f3, 5'd0, op};
        addr  = a;
        wdata = wd;
        start = 1'b1;
        seen  = 1'b0;
        n     = 0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk_eq("req_latency", 32'(o_mem_req), 32'(exp_req));
                if (!hold) start = 1'b0;
            end
            if (o_done) seen = 1'b1;
        end
        start = 1'b0;
        chk_eq("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            c = cpl_q.pop_front();
            chk_eq("cpl_err", 32'(o_err), 32'(c.err));
            chk_eq("cpl_rdata", o_rdata_out, c.rd);
            chk_eq("cpl_latency", 32'(n), 32'(exp_lat));
            chk_eq("cpl_busy", 32'(o_busy), 32'd1);
        end
        @(negedge clk);
    endtask

    initial begin
        #12;
        chk_eq("rst_busy", 32'(o_busy), 32'd0);
        chk_eq("rst_done", 32'(o_done), 32'd0);
        chk_eq("rst_req", 32'(o_mem_req), 32'd0);
        chk_eq("rst_be", 32'(o_mem_be), 32'd0);
        chk_eq("rst_addr", o_mem_addr, 32'd0);
        chk_eq("rst_rdata", o_rdata_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(OP_ST, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 1'b0, 1'b1, 4'b1000, 32'hA5A5A5A5, 1'b0, last_rd);
        last_rd = 32'h0000BEEF;
        do_op(OP_LD, 3'b001, 32'h202, 32'h0, 32'hBEEF1234, 3, 1'b0, 1'b1, 4'b1100, 32'h0, 1'b0, last_rd);
        last_rd = 32'h00AABBCC;
        do_op(OP_LD, 3'b100, 32'h101, 32'h0, 32'hAABBCCDD, 1, 1'b0, 1'b1, 4'b0010, 32'h0, 1'b0, last_rd);
        do_op(OP_ST, 3'b001, 32'h006, 32'h1234ABCD, 32'h0, 0, 1'b0, 1'b1, 4'b1100, 32'hABCDABCD, 1'b0, last_rd);
        do_op(OP_ST, 3'b010, 32'h010, 32'hDEADBEEF, 32'h0, 2, 1'b0, 1'b1, 4'b1111, 32'hDEADBEEF, 1'b0, last_rd);
`ifdef LSU_MISALIGN_TRAP_EN
        do_op(OP_LD, 3'b010, 32'h301, 32'h0, 32'h11223344, 0, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b1, last_rd);
        do_op(OP_LD, 3'b101, 32'h203, 32'h0, 32'hCAFEF00D, 0, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b1, last_rd);
`else
        last_rd = 32'h11223344;
        do_op(OP_LD, 3'b010, 32'h301, 32'h0, 32'h11223344, 0, 1'b0, 1'b1, 4'b1111, 32'h0, 1'b0, last_rd);
        last_rd = 32'h0000CAFE;
        do_op(OP_LD, 3'b101, 32'h203, 32'h0, 32'hCAFEF00D, 0, 1'b0, 1'b1, 4'b1100, 32'h0, 1'b0, last_rd);
`endif
        // Ready arriving one cycle too late loses to the timeout.
        do_op(OP_LD, 3'b010, 32'h400, 32'h0, 32'h55555555, TO, 1'b0, 1'b1, 4'b1111, 32'h0, 1'b1, last_rd);
        last_rd = 32'h0F0F0F0F;
        do_op(OP_LD, 3'b010, 32'h500, 32'h0, 32'h0F0F0F0F, TO - 1, 1'b0, 1'b1, 4'b1111, 32'h0, 1'b0, last_rd);
        do_op(OP_LD, 3'b011, 32'h000, 32'h0, 32'h0, 0, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b1, last_rd);
        do_op(OP_ST, 3'b010, 32'h020, 32'h01020304, 32'h0, 1, 1'b1, 1'b1, 4'b1111, 32'h01020304, 1'b0, last_rd);

        inst  = {17'd0, 3'b000, 5'd0, 7'b0110011};
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_eq("rtype_busy", 32'(o_busy), 32'd0);
            chk_eq("rtype_req", 32'(o_mem_req), 32'd0);
        end
        start = 1'b0;

        mem_wait = 1000;
        req_q.push_back('{addr: 32'h600, be: 4'b1111, wdata: 32'h0, we: 1'b0});
        exp_reqs++;
        inst  = {17'd0, 3'b010, 5'd0, OP_LD};
        addr  = 32'h600;
        wdata = 32'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_eq("pre_rst_req", 32'(o_mem_req), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("midrst_req", 32'(o_mem_req), 32'd0);
        chk_eq("midrst_busy", 32'(o_busy), 32'd0);
        chk_eq("midrst_done", 32'(o_done), 32'd0);
        chk_eq("midrst_rdata", o_rdata_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        last_rd = 32'h00000077;
        do_op(OP_LD, 3'b000, 32'h000, 32'h0, 32'h00000077, 0, 1'b0, 1'b1, 4'b0001, 32'h0, 1'b0, last_rd);

        repeat (4) @(negedge clk);
        chk_eq("done_total", 32'(n_done), 32'(exp_dones));
        chk_eq("req_total", 32'(n_reqs), 32'(exp_reqs));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
